// File: rtl/gmii_frame_checker_if.sv
// GMII receive bundle: byte data, data-valid and error, driven by the line side
// and consumed by the frame checker.
interface gmii_frame_checker_if;
  logic [7:0] gmii_d;
  logic       gmii_en;
  logic       gmii_er;

  modport master (output gmii_d, gmii_en, gmii_er);
  modport slave  (input  gmii_d, gmii_en, gmii_er);
endinterface

// File: rtl/gmii_frame_checker.sv
// GMII receive frame checker: delimits frames on gmii_en, validates preamble/SFD,
// checks the Ethernet CRC-32 residue and reports per-frame status plus counters.
module gmii_frame_checker #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  gmii_frame_checker_if.slave     gmii,
  output logic                    frame_done,
  output logic [15:0]             frame_len,
  output logic                    frame_fcs_ok,
  output logic                    frame_preamble_err,
  output logic                    frame_gmii_err,
  output logic                    frame_runt,
  output logic                    frame_oversize,
  output logic                    frame_good,
  output logic [31:0]             good_frames,
  output logic [31:0]             bad_frames
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  state_t      state;
  logic        en_q;
  logic [2:0]  pre_cnt;
  logic [31:0] crc;
  logic [15:0] len;
  logic        preamble_err;
  logic        gmii_err;

  // Reflected CRC-32 (poly 0xEDB88320), one byte per call, LSB first.
  function automatic logic [31:0] crc_update(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  logic        sof;
  logic        eof;
  logic        end_pre_err;
  logic [15:0] end_len;
  logic        end_fcs_ok;
  logic        end_runt;
  logic        end_oversize;
  logic        end_good;

  // End-of-frame classification; a frame that dies in PREAMBLE never saw an SFD.
  always_comb begin
    sof          = gmii.gmii_en && !en_q;
    eof          = !gmii.gmii_en && (state != IDLE);
    end_pre_err  = (state == PREAMBLE) || preamble_err;
    end_len      = end_pre_err ? 16'd0 : len;
    end_fcs_ok   = !end_pre_err && (crc == CRC_RESIDUE);
    end_runt     = !end_pre_err && (len < 16'(MIN_LEN));
    end_oversize = !end_pre_err && (len > 16'(MAX_LEN));
    end_good     = end_fcs_ok && !gmii_err && !end_runt && !end_oversize;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      en_q               <= 1'b1;
      pre_cnt            <= 3'd0;
      crc                <= CRC_INIT;
      len                <= 16'd0;
      preamble_err       <= 1'b0;
      gmii_err           <= 1'b0;
      frame_done         <= 1'b0;
      frame_len          <= 16'd0;
      frame_fcs_ok       <= 1'b0;
      frame_preamble_err <= 1'b0;
      frame_gmii_err     <= 1'b0;
      frame_runt         <= 1'b0;
      frame_oversize     <= 1'b0;
      frame_good         <= 1'b0;
      good_frames        <= 32'd0;
      bad_frames         <= 32'd0;
    end else begin
      en_q       <= gmii.gmii_en;
      frame_done <= 1'b0;

      if (eof) begin
        frame_done         <= 1'b1;
        frame_len          <= end_len;
        frame_fcs_ok       <= end_fcs_ok;
        frame_preamble_err <= end_pre_err;
        frame_gmii_err     <= gmii_err;
        frame_runt         <= end_runt;
        frame_oversize     <= end_oversize;
        frame_good         <= end_good;
        if (end_good) good_frames <= good_frames + 32'd1;
        else          bad_frames  <= bad_frames + 32'd1;
        state <= IDLE;
      end else begin
        if (gmii.gmii_en && gmii.gmii_er && (state != IDLE)) gmii_err <= 1'b1;

        case (state)
          // The start-of-frame byte is the first preamble byte, counted from zero.
          IDLE: begin
            if (sof) begin
              gmii_err     <= gmii.gmii_er;
              len          <= 16'd0;
              crc          <= CRC_INIT;
              if (gmii.gmii_d == 8'h55) begin
                pre_cnt      <= 3'd1;
                preamble_err <= 1'b0;
                state        <= PREAMBLE;
              end else begin
                pre_cnt      <= 3'd0;
                preamble_err <= 1'b1;
                state        <= DROP;
              end
            end
          end
          PREAMBLE: begin
            if (gmii.gmii_d == 8'h55 && pre_cnt != 3'd7) begin
              pre_cnt <= pre_cnt + 3'd1;
            end else if (gmii.gmii_d == 8'hD5 && pre_cnt != 3'd0) begin
              crc   <= CRC_INIT;
              len   <= 16'd0;
              state <= DATA;
            end else begin
              preamble_err <= 1'b1;
              state        <= DROP;
            end
          end
          DATA: begin
            if (len != 16'hFFFF) len <= len + 16'd1;
            crc <= crc_update(crc, gmii.gmii_d);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gmii_frame_checker.sv
// Directed bench for gmii_frame_checker: builds frames with a bench-side FCS and
// checks each status strobe and the cumulative counters against hand values.
module tb_gmii_frame_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gmii_frame_checker_if gif ();

  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_fcs_ok, frame_preamble_err, frame_gmii_err;
  logic        frame_runt, frame_oversize, frame_good;
  logic [31:0] good_frames, bad_frames;

  gmii_frame_checker #(.MAX_LEN(1518), .MIN_LEN(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .gmii               (gif.slave),
    .frame_done         (frame_done),
    .frame_len          (frame_len),
    .frame_fcs_ok       (frame_fcs_ok),
    .frame_preamble_err (frame_preamble_err),
    .frame_gmii_err     (frame_gmii_err),
    .frame_runt         (frame_runt),
    .frame_oversize     (frame_oversize),
    .frame_good         (frame_good),
    .good_frames        (good_frames),
    .bad_frames         (bad_frames)
  );

  int vectors = 0;
  int miscompares = 0;
  int strobe_count = 0;
  int good_strobes = 0;

  logic [7:0] tx_buf [0:1599];
  int         tx_len;

  always @(negedge clk) begin
    if (frame_done) begin
      strobe_count++;
      if (frame_good) good_strobes++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Bench-side CRC-32: feedback bit formed per data bit, reflected poly.
  function automatic logic [31:0] crcByte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  task automatic buildFrame(input int body_len, input int seed);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    tx_len = 0;
    for (int i = 0; i < 7; i++) begin
      tx_buf[tx_len] = 8'h55;
      tx_len++;
    end
    tx_buf[tx_len] = 8'hD5;
    tx_len++;
    crc = 32'hFFFF_FFFF;
    for (int k = 0; k < body_len - 4; k++) begin
      b = 8'(seed * 13 + k * 7 + 1);
      tx_buf[tx_len] = b;
      tx_len++;
      crc = crcByte(crc, b);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) begin
      tx_buf[tx_len] = fcs[8*k +: 8];
      tx_len++;
    end
  endtask

  task automatic applyStimulus(input int er_at, input int rst_at);
    for (int i = 0; i < tx_len; i++) begin
      gif.gmii_d  = tx_buf[i];
      gif.gmii_en = 1'b1;
      gif.gmii_er = (i == er_at);
      rst         = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
      @(posedge clk);
      #1;
    end
    rst         = 1'b0;
    gif.gmii_en = 1'b0;
    gif.gmii_er = 1'b0;
    gif.gmii_d  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    gif.gmii_en = 1'b0;
    gif.gmii_er = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;
  int base_good;

  initial begin
    gif.gmii_d  = 8'h00;
    gif.gmii_en = 1'b0;
    gif.gmii_er = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycles(2);

    checkOutput("reset_done", {31'd0, frame_done}, 32'd0);
    checkOutput("reset_len", {16'd0, frame_len}, 32'd0);
    checkOutput("reset_good_flag", {31'd0, frame_good}, 32'd0);
    checkOutput("reset_good_cnt", good_frames, 32'd0);
    checkOutput("reset_bad_cnt", bad_frames, 32'd0);

    // Ten good 64-byte frames, 12-cycle IPG.
    for (int f = 0; f < 10; f++) begin
      buildFrame(64, f);
      applyStimulus(-1, -1);
      idleCycles(12);
      checkOutput($sformatf("good%0d_strobes", f), strobe_count, f + 1);
      checkOutput($sformatf("good%0d_len", f), {16'd0, frame_len}, 32'd64);
      checkOutput($sformatf("good%0d_fcs", f), {31'd0, frame_fcs_ok}, 32'd1);
      checkOutput($sformatf("good%0d_good", f), {31'd0, frame_good}, 32'd1);
    end
    checkOutput("ten_good_cnt", good_frames, 32'd10);
    checkOutput("ten_bad_cnt", bad_frames, 32'd0);

    // One payload bit flipped after the FCS was computed.
    buildFrame(64, 3);
    tx_buf[20] = tx_buf[20] ^ 8'h04;
    applyStimulus(-1, -1);
    idleCycles(12);
    checkOutput("flip_fcs", {31'd0, frame_fcs_ok}, 32'd0);
    checkOutput("flip_good", {31'd0, frame_good}, 32'd0);
    checkOutput("flip_len", {16'd0, frame_len}, 32'd64);
    checkOutput("flip_bad_cnt", bad_frames, 32'd1);

    // Runt: 40 bytes after SFD with a valid FCS.
    buildFrame(40, 7);
    applyStimulus(-1, -1);
    idleCycles(12);
    checkOutput("runt_flag", {31'd0, frame_runt}, 32'd1);
    checkOutput("runt_fcs", {31'd0, frame_fcs_ok}, 32'd1);
    checkOutput("runt_good", {31'd0, frame_good}, 32'd0);
    checkOutput("runt_len", {16'd0, frame_len}, 32'd40);
    checkOutput("runt_bad_cnt", bad_frames, 32'd2);

    // Broken preamble: 55 55 55 5D then 60 bytes.
    tx_len = 0;
    for (int i = 0; i < 3; i++) begin
      tx_buf[tx_len] = 8'h55;
      tx_len++;
    end
    tx_buf[tx_len] = 8'h5D;
    tx_len++;
    for (int k = 0; k < 60; k++) begin
      tx_buf[tx_len] = 8'(k + 1);
      tx_len++;
    end
    applyStimulus(-1, -1);
    idleCycles(12);
    checkOutput("pre_err", {31'd0, frame_preamble_err}, 32'd1);
    checkOutput("pre_len", {16'd0, frame_len}, 32'd0);
    checkOutput("pre_fcs", {31'd0, frame_fcs_ok}, 32'd0);
    checkOutput("pre_runt", {31'd0, frame_runt}, 32'd0);
    checkOutput("pre_bad_cnt", bad_frames, 32'd3);

    // gmii_er pulsed once mid-payload of an otherwise valid frame.
    buildFrame(64, 9);
    applyStimulus(40, -1);
    idleCycles(12);
    checkOutput("er_flag", {31'd0, frame_gmii_err}, 32'd1);
    checkOutput("er_fcs", {31'd0, frame_fcs_ok}, 32'd1);
    checkOutput("er_good", {31'd0, frame_good}, 32'd0);
    checkOutput("er_bad_cnt", bad_frames, 32'd4);

    // Oversize: 1520 bytes after SFD.
    buildFrame(1520, 2);
    applyStimulus(-1, -1);
    idleCycles(12);
    checkOutput("over_flag", {31'd0, frame_oversize}, 32'd1);
    checkOutput("over_len", {16'd0, frame_len}, 32'd1520);
    checkOutput("over_fcs", {31'd0, frame_fcs_ok}, 32'd1);
    checkOutput("over_good", {31'd0, frame_good}, 32'd0);
    checkOutput("over_bad_cnt", bad_frames, 32'd5);
    checkOutput("over_good_cnt", good_frames, 32'd10);

    // Reset for 2 cycles at byte 30; the cut frame must not strobe.
    base = strobe_count;
    buildFrame(64, 4);
    applyStimulus(-1, 30);
    idleCycles(12);
    checkOutput("rst_no_strobe", strobe_count, base);
    checkOutput("rst_good_cnt", good_frames, 32'd0);
    checkOutput("rst_bad_cnt", bad_frames, 32'd0);
    checkOutput("rst_len_cleared", {16'd0, frame_len}, 32'd0);
    buildFrame(64, 6);
    applyStimulus(-1, -1);
    idleCycles(12);
    checkOutput("post_rst_strobe", strobe_count, base + 1);
    checkOutput("post_rst_good_cnt", good_frames, 32'd1);
    checkOutput("post_rst_bad_cnt", bad_frames, 32'd0);

    // Two good frames separated by a single idle cycle.
    base      = strobe_count;
    base_good = good_strobes;
    buildFrame(64, 11);
    applyStimulus(-1, -1);
    idleCycles(1);
    buildFrame(64, 12);
    applyStimulus(-1, -1);
    idleCycles(12);
    checkOutput("b2b_strobes", strobe_count, base + 2);
    checkOutput("b2b_good_strobes", good_strobes, base_good + 2);
    checkOutput("b2b_good_cnt", good_frames, 32'd3);
    checkOutput("b2b_bad_cnt", bad_frames, 32'd0);
    checkOutput("b2b_len", {16'd0, frame_len}, 32'd64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
